// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Contents: FSM state enum, opcode/funct codes, datapath mux encodings,
// ALU operation class used between the FSM and the ALU decoder.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    BRANCH,
    IMMEX,
    IMMWB,
    JUMP
  } mc_state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU source B select
  localparam logic [2:0] SRCB_B       = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_SIMM    = 3'b010;
  localparam logic [2:0] SRCB_SIMM_SH = 3'b011;
  localparam logic [2:0] SRCB_ZIMM    = 3'b100;

  // Next-PC select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Operation class requested by the FSM; FUNCT defers to the R-type funct field.
  typedef enum logic [1:0] {
    AOP_ADD,
    AOP_SUB,
    AOP_FUNCT,
    AOP_OR
  } aluop_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's operation class plus funct onto alucontrol.
// Ports: aluop (class), funct (instr[5:0]) in; alucontrol, funct_bad out.
// funct_bad reflects funct alone so DECODE can reject R-types before EXEC.
module mc_aludec
  import mips_mc_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        funct_bad
);

  logic [2:0] funct_ctl;

  always_comb begin
    funct_ctl = ALU_ADD;
    funct_bad = 1'b0;
    case (funct)
      F_ADD:   funct_ctl = ALU_ADD;
      F_SUB:   funct_ctl = ALU_SUB;
      F_AND:   funct_ctl = ALU_AND;
      F_OR:    funct_ctl = ALU_OR;
      F_SLT:   funct_ctl = ALU_SLT;
      default: funct_bad = 1'b1;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      AOP_ADD:   alucontrol = ALU_ADD;
      AOP_SUB:   alucontrol = ALU_SUB;
      AOP_OR:    alucontrol = ALU_OR;
      AOP_FUNCT: alucontrol = funct_ctl;
      default:   alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM driving a shared ALU/memory datapath.
// Ports: clk, reset (async active-low), op/funct from IR, zero, mem_ready in;
// datapath strobes/selects and illegal_op out. Optional MC_PERF_EN adds
// CNT_W-wide instr_cnt/cycle_cnt outputs (and the CNT_W parameter).
module mips_mc_controller
  import mips_mc_pkg::*;
`ifdef MC_PERF_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcen,
  output logic        irwrite,
  output logic        iord,
  output logic        memwrite,
  output logic        regwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        alusrca,
  output logic [2:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic        illegal_op
`ifdef MC_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  mc_state_t  state, state_nxt;
  aluop_t     aluop;
  logic       funct_bad;
  logic [2:0] alu_ctl;

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alu_ctl),
    .funct_bad  (funct_bad)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    aluop      = AOP_ADD;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_FOUR;
    pcsrc      = PC_ALU;
    illegal_op = 1'b0;

    case (state)
      FETCH: begin
        // PC+4 and IR load commit together on the cycle memory delivers.
        pcen    = mem_ready;
        irwrite = mem_ready;
        if (mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        alusrcb   = SRCB_SIMM_SH;
        state_nxt = FETCH;
        case (op)
          OP_LW, OP_SW:   state_nxt = MEMADR;
          OP_BEQ, OP_BNE: state_nxt = BRANCH;
          OP_ADDI, OP_ORI: state_nxt = IMMEX;
          OP_J:           state_nxt = JUMP;
          OP_RTYPE: begin
            if (funct_bad) illegal_op = 1'b1;
            else           state_nxt  = EXEC;
          end
          default: illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_SIMM;
        state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_nxt = MEMWB;
      end
      MEMWB: begin
        regwrite  = 1'b1;
        memtoreg  = 1'b1;
        state_nxt = FETCH;
      end
      MEMWR: begin
        // Write strobe stays up through the completing cycle.
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_nxt = FETCH;
      end
      EXEC: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_B;
        aluop     = AOP_FUNCT;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        regwrite  = 1'b1;
        regdst    = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_B;
        aluop     = AOP_SUB;
        pcsrc     = PC_ALUOUT;
        pcen      = (op == OP_BNE) ? ~zero : zero;
        state_nxt = FETCH;
      end
      IMMEX: begin
        alusrca = 1'b1;
        if (op == OP_ORI) begin
          alusrcb = SRCB_ZIMM;
          aluop   = AOP_OR;
        end else begin
          alusrcb = SRCB_SIMM;
        end
        state_nxt = IMMWB;
      end
      IMMWB: begin
        regwrite  = 1'b1;
        state_nxt = FETCH;
      end
      JUMP: begin
        pcsrc     = PC_JUMP;
        pcen      = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase

    alucontrol = alu_ctl;

    // While reset is held, FETCH's mem_ready-driven strobes must stay quiet.
    if (!reset) begin
      pcen       = 1'b0;
      irwrite    = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_FOUR;
      pcsrc      = PC_ALU;
      alucontrol = ALU_ADD;
      illegal_op = 1'b0;
    end
  end

`ifdef MC_PERF_EN
  logic retire;

  // Final state of every legal instruction; illegal ones end in DECODE and are not counted.
  always_comb begin
    retire = 1'b0;
    case (state)
      MEMWB, ALUWB, IMMWB, BRANCH, JUMP: retire = 1'b1;
      MEMWR:                             retire = mem_ready;
      default:                           retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
